// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU op encoding, datapath widths, the EX control
// bundle with its bubble value, and the operand forwarding-select encoding.
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Where an EX operand comes from; EX/MEM outranks MEM/WB.
    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic [3:0] alu_control;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE_CTRL = '{
        valid:       1'b0,
        reg_write:   1'b0,
        mem_read:    1'b0,
        mem_write:   1'b0,
        branch:      1'b0,
        alu_src:     1'b0,
        alu_control: ALU_ADD
    };

endpackage

// File: rtl/operand_fwd_mux.sv
// One EX operand forwarding mux: compares the registered source index against
// the EX/MEM and MEM/WB destinations and selects the freshest value.
module operand_fwd_mux
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [XLEN-1:0]   reg_data_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              exmem_reg_write_i,
    input  logic [XLEN-1:0]   exmem_data_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic              memwb_reg_write_i,
    input  logic [XLEN-1:0]   memwb_data_i,
    output logic [XLEN-1:0]   fwd_data_o
);

    logic     exmem_hit;
    logic     memwb_hit;
    fwd_sel_e fwd_sel;

    // x0 is hard-wired zero, so a write to it must never be forwarded.
    assign exmem_hit = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i);
    assign memwb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i);

    always_comb begin
        fwd_sel = FWD_REG;
        if (exmem_hit) begin
            fwd_sel = FWD_EXMEM;
        end else if (memwb_hit) begin
            fwd_sel = FWD_MEMWB;
        end
    end

    always_comb begin
        fwd_data_o = reg_data_i;
        case (fwd_sel)
            FWD_EXMEM: fwd_data_o = exmem_data_i;
            FWD_MEMWB: fwd_data_o = memwb_data_i;
            default:   fwd_data_o = reg_data_i;
        endcase
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands/controls,
// bypasses write-back at capture, forwards EX/MEM and MEM/WB, inserts load-use bubbles.
module id_ex_stage_reg
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [3:0]        id_alu_control,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_branch,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic [XLEN-1:0]   exmem_alu_result,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [XLEN-1:0]   memwb_result,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_srcA,
    output logic [XLEN-1:0]   ex_srcB,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [3:0]        ex_alu_control,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic              hazard_stall
);

    // Valid semantics: id_valid marks a real instruction in ID; ex_valid marks
    // a real instruction in EX. hazard_stall holds IF/ID for one cycle while a
    // bubble enters EX; stall freezes this stage entirely.

    ex_ctrl_t          ctrl_q,     ctrl_d;
    logic [REG_AW-1:0] rd_q,       rd_d;
    logic [REG_AW-1:0] rs1_q,      rs1_d;
    logic [REG_AW-1:0] rs2_q,      rs2_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]   imm_q,      imm_d;

    logic [XLEN-1:0]   rs1_cap;
    logic [XLEN-1:0]   rs2_cap;
    logic [XLEN-1:0]   fwd_a;
    logic [XLEN-1:0]   fwd_b;
    logic              load_use;

    // Load in EX whose destination is read by the instruction now in ID.
    assign load_use = id_valid && ctrl_q.valid && ctrl_q.mem_read && (rd_q != '0)
                      && ((rd_q == id_rs1) || (rd_q == id_rs2));
    assign hazard_stall = load_use;

    // The register file is read before write-back lands, so take the WB value directly.
    assign rs1_cap = (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs1))
                     ? memwb_result : id_rs1_data;
    assign rs2_cap = (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs2))
                     ? memwb_result : id_rs2_data;

    always_comb begin
        ctrl_d     = ctrl_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        if (!stall) begin
            if (flush || load_use) begin
                ctrl_d     = BUBBLE_CTRL;
                rd_d       = '0;
                rs1_d      = '0;
                rs2_d      = '0;
                rs1_data_d = '0;
                rs2_data_d = '0;
                imm_d      = '0;
            end else begin
                ctrl_d.valid       = id_valid;
                ctrl_d.reg_write   = id_reg_write;
                ctrl_d.mem_read    = id_mem_read;
                ctrl_d.mem_write   = id_mem_write;
                ctrl_d.branch      = id_branch;
                ctrl_d.alu_src     = id_alu_src;
                ctrl_d.alu_control = id_alu_control;
                rd_d               = id_rd;
                rs1_d              = id_rs1;
                rs2_d              = id_rs2;
                rs1_data_d         = rs1_cap;
                rs2_data_d         = rs2_cap;
                imm_d              = id_imm;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= BUBBLE_CTRL;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
        end
    end

    operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_a (
        .rs_i              (rs1_q),
        .reg_data_i        (rs1_data_q),
        .exmem_rd_i        (exmem_rd),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_data_i      (exmem_alu_result),
        .memwb_rd_i        (memwb_rd),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_data_i      (memwb_result),
        .fwd_data_o        (fwd_a)
    );

    operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_b (
        .rs_i              (rs2_q),
        .reg_data_i        (rs2_data_q),
        .exmem_rd_i        (exmem_rd),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_data_i      (exmem_alu_result),
        .memwb_rd_i        (memwb_rd),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_data_i      (memwb_result),
        .fwd_data_o        (fwd_b)
    );

    assign ex_valid       = ctrl_q.valid;
    assign ex_reg_write   = ctrl_q.reg_write;
    assign ex_mem_read    = ctrl_q.mem_read;
    assign ex_mem_write   = ctrl_q.mem_write;
    assign ex_branch      = ctrl_q.branch;
    assign ex_alu_control = ctrl_q.alu_control;
    assign ex_rd          = rd_q;
    assign ex_srcA        = fwd_a;
    assign ex_store_data  = fwd_b;
    assign ex_srcB        = ctrl_q.alu_src ? imm_q : fwd_b;

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline stage that sits directly upstream of the execute-stage ALU. It latches decoded operands and control signals, then drives the ALU's srcA, srcB and 4-bit alu_control.
- Resolves data hazards in two ways: EX/MEM and MEM/WB forwarding on the registered operands, and write-back bypass at capture time.
- Detects load-use hazards and inserts a bubble. Also supports external stall and flush.

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register-index width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  global freeze from memory; hold all state
- flush  in  1  branch-mispredict kill; load bubble
- id_valid  in  1  ID slot holds a real instruction
- id_rs1_data, id_rs2_data, id_imm  in  XLEN  register-file reads and immediate
- id_rs1, id_rs2, id_rd  in  REG_AW  register indices
- id_alu_control  in  4  ALU op (shared encoding)
- id_alu_src  in  1  1 selects imm for srcB
- id_reg_write, id_mem_read, id_mem_write, id_branch  in  1 each  control bits
- exmem_rd  in  REG_AW; exmem_reg_write  in  1; exmem_alu_result  in  XLEN
- memwb_rd  in  REG_AW; memwb_reg_write  in  1; memwb_result  in  XLEN
- ex_valid  out  1
- ex_srcA, ex_srcB, ex_store_data  out  XLEN  ALU operands and forwarded rs2 for stores
- ex_alu_control  out  4
- ex_rd  out  REG_AW
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1 each
- hazard_stall  out  1  tells IF/ID to hold

Behaviour:
- Reset (async, rst=1): valid=0, every control bit=0, alu_control=ADD (0000), data registers=0, rd/rs indices=0. Consequently ex_srcA=ex_srcB=0 while exmem/memwb forwarding is inactive.
- Latency: one cycle from ID inputs to EX outputs.
- Register update priority on each rising clk edge: rst > stall (hold everything) > flush (bubble) > hazard_stall (bubble) > normal load.
- Bubble contents: valid=0, reg_write=mem_read=mem_write=branch=0, alu_control=ADD, rd=0. Data fields are don't-care but must be zeroed.
- Load-use detection (combinational):
  - hazard_stall = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - The consumer stays in ID for exactly one cycle and then loads normally.
- Capture-time bypass on normal load: if memwb_reg_write & memwb_rd!=0 & memwb_rd==id_rs1, capture memwb_result instead of id_rs1_data. Apply the same rule to rs2.
- EX forwarding (combinational on registered rs1/rs2):
  - EX/MEM match (reg_write, rd!=0, rd==rs) takes priority, then MEM/WB match, else the registered data.
  - Result is fwdA and fwdB.
- Output operands:
  - ex_srcA = fwdA.
  - ex_store_data = fwdB.
  - ex_srcB = imm if alu_src, else fwdB.
- Register x0 is never forwarded or bypassed.
- Simultaneous events:
  - stall with flush: stall wins; the flush request must be held by its source.
  - flush with hazard_stall: the bubble is the same either way. hazard_stall is still driven, and IF/ID flush logic overrides it.
- hazard_stall is suppressed when id_valid=0.
- While stall=1, outputs remain constant, provided the forwarding inputs are also frozen.

Decomposition:
- Shared package pipe_pkg holds:
  - ALU op constants ALU_ADD..ALU_SLT (0000..0111)
  - XLEN, REG_AW
  - bubble control constant
  - forwarding-select encoding (FWD_REG, FWD_MEMWB, FWD_EXMEM)
- Sub-module operand_fwd_mux, instantiated twice (rs1, rs2): performs the index compare, applies priority, and selects the XLEN data.

Test Plan:
- Reset mid-stream: assert rst asynchronously between edges -> ex_valid=0, all controls=0, ex_alu_control=0000 immediately, without waiting for clk.
- EX/MEM forward: exmem_rd=5, exmem_reg_write=1, exmem_alu_result=0x0000_00AA, registered rs1=5 with stale data 0x11, and memwb_rd=5 with 0x22 -> ex_srcA=0xAA (EX/MEM wins over MEM/WB).
- x0 guard: exmem_rd=0, exmem_reg_write=1, result 0xFFFF_FFFF, rs1=0, id_rs1_data=0 -> ex_srcA=0.
- Load-use: EX holds lw with rd=7 (mem_read=1); ID presents add with rs2=7 -> hazard_stall=1 for one cycle, next EX is a bubble (valid=0, reg_write=0). Following cycle the add loads, and MEM/WB forwarding supplies 0x1234 to ex_srcB.
- Stall/flush priority: stall=1 and flush=1 with valid instruction in EX -> EX contents unchanged. Then stall=0 with flush=1 -> bubble loaded.
- Immediate select: id_alu_src=1, imm=0xFFFF_FFFC, rs2 forwarded value 0x50 -> ex_srcB=0xFFFF_FFFC, ex_store_data=0x50.
